// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-like to AXI bridge.
package bridge_pkg;

    // Bridge FSM: one outstanding AXI transaction at a time.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_AWW = 3'd3,
        WR_B   = 3'd4
    } bridge_state_e;

    // Owner IDs double as the AXI arid/awid/wid values.
    localparam logic [3:0] OWNER_INST = 4'd0;
    localparam logic [3:0] OWNER_DATA = 4'd1;

    // Fixed AXI fields: single-beat INCR, no lock/cache/prot.
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [1:0] LOCK_NONE  = 2'b00;
    localparam logic [3:0] CACHE_NONE = 4'b0000;
    localparam logic [2:0] PROT_NONE  = 3'b000;

endpackage

// File: rtl/sram_like_axi_bridge_if.sv
// Bus interfaces of the bridge: one SRAM-like port type (used for both
// fetch and data) and the AXI master bus.
//
// Handshake semantics: an SRAM-like request is taken in the cycle where
// req and addr_ok are both 1; data_ok is a one-cycle completion pulse.
// On AXI a beat transfers in the cycle where valid and ready are both 1;
// a valid, once raised, holds with stable payload until its ready.
interface sram_like_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    // Core side issues requests.
    modport master (output req, wr, size, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    // Bridge side accepts them.
    modport slave  (input  req, wr, size, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                rready;
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [3:0]          wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic                bvalid;
    logic                bready;

    modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                    input  arready,
                    input  rdata, rvalid,
                    output rready,
                    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                    input  awready,
                    output wid, wdata, wstrb, wlast, wvalid,
                    input  wready,
                    input  bvalid,
                    output bready);
    modport slave  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                    output arready,
                    output rdata, rvalid,
                    input  rready,
                    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                    output awready,
                    input  wid, wdata, wstrb, wlast, wvalid,
                    output wready,
                    output bvalid,
                    input  bready);
endinterface

// File: rtl/sram_like_axi_bridge_wstrb_gen.sv
// Byte-strobe generator: maps access size and low address bits onto the
// byte lanes of a 32-bit word. Store data is already lane-aligned by the core.
module axi_wstrb_gen (
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] wstrb_o
);

    // Size decode; size 3 is not issued by the core and falls back to a full word.
    always_comb begin
        wstrb_o = 4'b1111;
        case (size_i)
            2'd0:    wstrb_o = 4'b0001 << addr_lo_i;
            2'd1:    wstrb_o = 4'b0011 << addr_lo_i;
            default: wstrb_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// Bridges the core's fetch and data SRAM-like ports onto one AXI master.
// Data has priority; only one transaction is in flight, so the response
// is steered by a latched owner rather than by AXI ID.
module sram_like_axi_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    sram_like_if.slave    inst_if,
    sram_like_if.slave    data_if,
    axi_if.master         axi,
    output bridge_state_e dbg_state_o
);

    bridge_state_e       state_q, state_d;
    logic [3:0]          owner_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    logic                accept;
    logic                sel_data;
    logic [ADDR_W-1:0]   req_addr;
    logic [1:0]          req_size;
    logic                req_wr;
    logic [3:0]          req_wstrb;

    // Fetch never writes; its wr/wdata are intentionally ignored.
    logic                unused_inst_fields;
    assign unused_inst_fields = ^{inst_if.wr, inst_if.wdata};

    // Request selection: data wins whenever it asks.
    assign sel_data = data_if.req;
    assign accept   = (state_q == IDLE) && (data_if.req || inst_if.req);
    assign req_addr = sel_data ? data_if.addr : inst_if.addr;
    assign req_size = sel_data ? data_if.size : inst_if.size;
    assign req_wr   = sel_data && data_if.wr;

    axi_wstrb_gen u_wstrb_gen (
        .size_i    (req_size),
        .addr_lo_i (req_addr[1:0]),
        .wstrb_o   (req_wstrb)
    );

    // State and per-transaction latches; latches only move on acceptance so
    // the AXI payload stays stable while any valid is up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_INST;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= 2'd0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (accept) begin
                owner_q <= sel_data ? OWNER_DATA : OWNER_INST;
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                size_q  <= req_size;
                wdata_q <= data_if.wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    // Next-state and handshake outputs; completion pulses are combinational
    // from rvalid/bvalid so a response costs no extra cycle.
    always_comb begin
        state_d          = state_q;
        aw_done_d        = aw_done_q;
        w_done_d         = w_done_q;
        inst_if.addr_ok  = 1'b0;
        inst_if.data_ok  = 1'b0;
        inst_if.rdata    = '0;
        data_if.addr_ok  = 1'b0;
        data_if.data_ok  = 1'b0;
        data_if.rdata    = '0;
        axi.arvalid      = 1'b0;
        axi.rready       = 1'b0;
        axi.awvalid      = 1'b0;
        axi.wvalid       = 1'b0;
        axi.bready       = 1'b0;

        case (state_q)
            IDLE: begin
                data_if.addr_ok = data_if.req;
                inst_if.addr_ok = inst_if.req && !data_if.req;
                aw_done_d       = 1'b0;
                w_done_d        = 1'b0;
                if (accept) begin
                    state_d = req_wr ? WR_AWW : RD_AR;
                end
            end
            RD_AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    if (owner_q == OWNER_DATA) begin
                        data_if.data_ok = 1'b1;
                        data_if.rdata   = axi.rdata;
                    end else begin
                        inst_if.data_ok = 1'b1;
                        inst_if.rdata   = axi.rdata;
                    end
                    state_d = IDLE;
                end
            end
            WR_AWW: begin
                axi.awvalid = !aw_done_q;
                axi.wvalid  = !w_done_q;
                aw_done_d   = aw_done_q || axi.awready;
                w_done_d    = w_done_q || axi.wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    data_if.data_ok = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address/data payload straight from the latches; the rest is constant.
    assign axi.arid    = owner_q;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = LEN_SINGLE;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = LOCK_NONE;
    assign axi.arcache = CACHE_NONE;
    assign axi.arprot  = PROT_NONE;

    assign axi.awid    = OWNER_DATA;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = LEN_SINGLE;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = LOCK_NONE;
    assign axi.awcache = CACHE_NONE;
    assign axi.awprot  = PROT_NONE;

    assign axi.wid     = OWNER_DATA;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;

    assign dbg_state_o = state_q;

    // wr_q records the transaction direction for debug visibility.
    logic unused_wr;
    assign unused_wr = wr_q;

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Directed bench for sram_like_axi_bridge. Inputs change and outputs are
// sampled in the low phase of the clock, away from the rising edge.
module tb_sram_like_axi_bridge;
    import bridge_pkg::*;

    logic          clk;
    logic          rst;
    bridge_state_e dbg_state;

    sram_like_if inst_bus ();
    sram_like_if data_bus ();
    axi_if       axi_bus ();

    sram_like_axi_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .inst_if     (inst_bus),
        .data_if     (data_bus),
        .axi         (axi_bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int aw_hs_cnt = 0;
    int data_ok_cnt = 0;
    int inst_ok_cnt = 0;
    logic [31:0] exp_q[$];

    // Handshake/pulse counters sampled at the active edge.
    always @(posedge clk) begin
        if (axi_bus.awvalid && axi_bus.awready) aw_hs_cnt <= aw_hs_cnt + 1;
        if (data_bus.data_ok) data_ok_cnt <= data_ok_cnt + 1;
        if (inst_bus.data_ok) inst_ok_cnt <= inst_ok_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare a returned read word against the oldest expected one.
    task automatic check_read(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got %h with no expected read queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_bus.req   = 1'b0;
        inst_bus.wr    = 1'b0;
        inst_bus.size  = 2'd2;
        inst_bus.addr  = '0;
        inst_bus.wdata = '0;
        data_bus.req   = 1'b0;
        data_bus.wr    = 1'b0;
        data_bus.size  = 2'd2;
        data_bus.addr  = '0;
        data_bus.wdata = '0;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rdata   = '0;
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        axi_bus.bvalid  = 1'b0;
    endtask

    task automatic data_req(input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        data_bus.req   = 1'b1;
        data_bus.wr    = wr;
        data_bus.size  = size;
        data_bus.addr  = addr;
        data_bus.wdata = wdata;
    endtask

    task automatic inst_req(input logic [31:0] addr);
        inst_bus.req  = 1'b1;
        inst_bus.size = 2'd2;
        inst_bus.addr = addr;
    endtask

    int cnt0;

    initial begin
        rst = 1'b0;
        idle_inputs();
        #1;
        // reset state
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_valids", {axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid,
                             axi_bus.rready, axi_bus.bready}, 0);
        check("rst_oks", {inst_bus.addr_ok, inst_bus.data_ok,
                          data_bus.addr_ok, data_bus.data_ok}, 0);
        repeat (2) cyc();
        rst = 1'b1;

        // 1) single fetch, immediate arready/rvalid
        cyc(); inst_req(32'hBFC00000); axi_bus.arready = 1'b1; #1;
        check("t1_inst_addr_ok", inst_bus.addr_ok, 1);
        check("t1_data_addr_ok", data_bus.addr_ok, 0);
        cyc(); inst_bus.req = 1'b0; #1;
        check("t1_arvalid", axi_bus.arvalid, 1);
        check("t1_arid", axi_bus.arid, 0);
        check("t1_arsize", axi_bus.arsize, 2);
        check("t1_araddr", axi_bus.araddr, 32'hBFC00000);
        exp_q.push_back(32'h3C1D8000);
        cyc(); axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'h3C1D8000; #1;
        check("t1_rready", axi_bus.rready, 1);
        check("t1_inst_data_ok", inst_bus.data_ok, 1);
        check_read("t1_inst_rdata", inst_bus.rdata);
        check("t1_data_data_ok", data_bus.data_ok, 0);
        cyc(); axi_bus.rvalid = 1'b0; #1;
        check("t1_back_idle", 32'(dbg_state), 32'(IDLE));
        check("t1_arvalid_low", axi_bus.arvalid, 0);

        // 2) simultaneous requests: data first, fetch after data_ok
        cyc(); inst_req(32'hBFC00004); data_req(1'b0, 2'd2, 32'h80001004, 0); #1;
        check("t2_data_addr_ok", data_bus.addr_ok, 1);
        check("t2_inst_addr_ok_lost", inst_bus.addr_ok, 0);
        cyc(); data_bus.req = 1'b0; #1;
        check("t2_arid_data", axi_bus.arid, 1);
        check("t2_araddr", axi_bus.araddr, 32'h80001004);
        check("t2_inst_wait_ar", inst_bus.addr_ok, 0);
        exp_q.push_back(32'h11223344);
        cyc(); axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'h11223344; #1;
        check("t2_data_data_ok", data_bus.data_ok, 1);
        check_read("t2_data_rdata", data_bus.rdata);
        check("t2_inst_data_ok", inst_bus.data_ok, 0);
        check("t2_inst_wait_r", inst_bus.addr_ok, 0);
        cyc(); axi_bus.rvalid = 1'b0; #1;
        check("t2_inst_addr_ok", inst_bus.addr_ok, 1);
        cyc(); inst_bus.req = 1'b0; #1;
        check("t2_arid_inst", axi_bus.arid, 0);
        check("t2_araddr_inst", axi_bus.araddr, 32'hBFC00004);
        exp_q.push_back(32'h24080001);
        cyc(); axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'h24080001; #1;
        check("t2_inst_data_ok2", inst_bus.data_ok, 1);
        check_read("t2_inst_rdata", inst_bus.rdata);
        cyc(); axi_bus.rvalid = 1'b0; axi_bus.arready = 1'b0;

        // 3) byte store 0xAB at 0x80000003
        axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
        data_req(1'b1, 2'd0, 32'h80000003, 32'hAB000000); #1;
        check("t3_addr_ok", data_bus.addr_ok, 1);
        cyc(); data_bus.req = 1'b0; #1;
        check("t3_awvalid", axi_bus.awvalid, 1);
        check("t3_wvalid", axi_bus.wvalid, 1);
        check("t3_wstrb", axi_bus.wstrb, 4'b1000);
        check("t3_awsize", axi_bus.awsize, 0);
        check("t3_awaddr", axi_bus.awaddr, 32'h80000003);
        check("t3_wdata", axi_bus.wdata, 32'hAB000000);
        check("t3_awid", axi_bus.awid, 1);
        cyc(); #1;
        check("t3_bready", axi_bus.bready, 1);
        check("t3_no_ok_before_b", data_bus.data_ok, 0);
        cyc(); axi_bus.bvalid = 1'b1; #1;
        check("t3_data_ok", data_bus.data_ok, 1);
        cyc(); axi_bus.bvalid = 1'b0; axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;

        // 4) halfword store, awready at T+1, wready at T+4
        cnt0 = aw_hs_cnt;
        data_req(1'b1, 2'd1, 32'h80000012, 32'h5A5A0000); #1;
        check("t4_addr_ok", data_bus.addr_ok, 1);
        cyc(); data_bus.req = 1'b0; axi_bus.awready = 1'b1; #1;
        check("t4_awvalid_t1", axi_bus.awvalid, 1);
        check("t4_wvalid_t1", axi_bus.wvalid, 1);
        check("t4_wstrb", axi_bus.wstrb, 4'b1100);
        cyc(); axi_bus.awready = 1'b0; #1;
        check("t4_awvalid_t2", axi_bus.awvalid, 0);
        check("t4_wvalid_t2", axi_bus.wvalid, 1);
        cyc(); #1;
        check("t4_wvalid_t3", axi_bus.wvalid, 1);
        check("t4_awvalid_t3", axi_bus.awvalid, 0);
        cyc(); axi_bus.wready = 1'b1; #1;
        check("t4_wvalid_t4", axi_bus.wvalid, 1);
        check("t4_bready_t4", axi_bus.bready, 0);
        cyc(); axi_bus.wready = 1'b0; axi_bus.awready = 1'b1; axi_bus.bvalid = 1'b1; #1;
        check("t4_state_t5", 32'(dbg_state), 32'(WR_B));
        check("t4_valids_t5", {axi_bus.awvalid, axi_bus.wvalid}, 0);
        check("t4_data_ok", data_bus.data_ok, 1);
        cyc(); axi_bus.bvalid = 1'b0; axi_bus.awready = 1'b0; #1;
        check("t4_one_aw", aw_hs_cnt - cnt0, 1);

        // 5) load with rvalid 10 cycles late while fetch keeps asking
        cnt0 = data_ok_cnt;
        axi_bus.arready = 1'b1;
        inst_req(32'hBFC00010); data_req(1'b0, 2'd2, 32'h80002000, 0); #1;
        check("t5_data_addr_ok", data_bus.addr_ok, 1);
        cyc(); data_bus.req = 1'b0; #1;
        check("t5_arvalid", axi_bus.arvalid, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            check($sformatf("t5_rready_%0d", i), axi_bus.rready, 1);
            check($sformatf("t5_inst_hold_%0d", i), inst_bus.addr_ok, 0);
        end
        exp_q.push_back(32'hCAFEF00D);
        cyc(); axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'hCAFEF00D; #1;
        check("t5_data_ok", data_bus.data_ok, 1);
        check_read("t5_rdata", data_bus.rdata);
        cyc(); axi_bus.rvalid = 1'b0; #1;
        check("t5_one_data_ok", data_ok_cnt - cnt0, 1);
        check("t5_inst_addr_ok", inst_bus.addr_ok, 1);
        cyc(); inst_bus.req = 1'b0; #1;
        check("t5_inst_araddr", axi_bus.araddr, 32'hBFC00010);
        exp_q.push_back(32'h00000000);
        cyc(); axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'h00000000; #1;
        check("t5_inst_data_ok", inst_bus.data_ok, 1);
        check_read("t5_inst_rdata", inst_bus.rdata);
        cyc(); axi_bus.rvalid = 1'b0;

        // 6) reset while waiting in RD_R
        inst_req(32'hBFC00020); #1;
        check("t6_addr_ok", inst_bus.addr_ok, 1);
        cyc(); inst_bus.req = 1'b0;
        cyc(); #1;
        check("t6_in_rd_r", 32'(dbg_state), 32'(RD_R));
        rst = 1'b0; #1;
        check("t6_rst_valids", {axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid,
                                axi_bus.rready, axi_bus.bready}, 0);
        check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
        cyc(); rst = 1'b1;
        cyc(); data_req(1'b0, 2'd2, 32'h80003000, 0); #1;
        check("t6_new_addr_ok", data_bus.addr_ok, 1);
        cyc(); data_bus.req = 1'b0; #1;
        check("t6_arid", axi_bus.arid, 1);
        check("t6_araddr", axi_bus.araddr, 32'h80003000);
        exp_q.push_back(32'h0BADBEEF);
        cyc(); axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'h0BADBEEF; #1;
        check("t6_data_ok", data_bus.data_ok, 1);
        check_read("t6_rdata", data_bus.rdata);
        cyc(); idle_inputs(); #1;
        check("t6_final_idle", 32'(dbg_state), 32'(IDLE));
        check("t6_queue_empty", exp_q.size(), 0);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
